// File: rtl/cacheline_burst_adapter.sv
// cacheline_burst_adapter: takes one 256-bit line read/write from an L1 cache and moves it to
// or from memory as a 4-beat burst of 64-bit words. It then returns a one-cycle line response.
// Optional feature macro: BURST_CRITICAL_WORD_FIRST_EN. When it is defined, a read burst
// starts at the addressed beat and wraps around the line.
module cacheline_burst_adapter #(
   parameter int unsigned S_LINE = 256,
   parameter int unsigned S_BEAT = 64
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [31:0]       i_line_address,
   input  logic              i_line_read,
   input  logic              i_line_write,
   input  logic [S_LINE-1:0] i_line_wdata,
   output logic [S_LINE-1:0] o_line_rdata,
   output logic              o_line_resp,
   output logic [31:0]       o_burst_address,
   output logic              o_burst_read,
   output logic              o_burst_write,
   output logic [S_BEAT-1:0] o_burst_wdata,
   input  logic [S_BEAT-1:0] i_burst_rdata,
   input  logic              i_burst_resp
);

   localparam int unsigned N_BEATS = S_LINE / S_BEAT;

   typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

   state_e            r_state, w_state_next;
   logic [1:0]        r_cnt, w_cnt_next;
   logic [1:0]        w_k0;      // first beat of a read burst
   logic [1:0]        w_start;   // first beat of the burst in flight
   logic              w_last;
   logic [31:0]       r_addr;
   logic [S_LINE-1:0] r_wdata;
   logic [S_LINE-1:0] r_rdata;
   logic              w_unused;

   // The low five address bits only matter for the beat select.
   assign w_unused = ^i_line_address[4:0];

`ifdef BURST_CRITICAL_WORD_FIRST_EN
   logic [1:0] r_start;

   assign w_k0    = i_line_address[4:3];
   assign w_start = r_start;

   // Remember where the burst began so that its end can be found after the counter wraps.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_start <= 2'd0;
      end else if (r_state == StIdle) begin
         if (i_line_write) begin
            r_start <= 2'd0;
         end else if (i_line_read) begin
            r_start <= w_k0;
         end
      end
   end
`else
   assign w_k0    = 2'd0;
   assign w_start = 2'd0;
`endif

   // The last beat is the one that sits just before the start beat, modulo 4.
   assign w_last = ((r_cnt + 2'd1) == w_start);

   // Next-state and beat-counter logic.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      unique case (r_state)
         StIdle: begin
            if (i_line_write) begin
               w_state_next = StWr;
               w_cnt_next   = 2'd0;
            end else if (i_line_read) begin
               w_state_next = StRd;
               w_cnt_next   = w_k0;
            end
         end
         StRd, StWr: begin
            if (i_burst_resp) begin
               if (w_last) begin
                  w_state_next = StDone;
               end else begin
                  w_cnt_next = r_cnt + 2'd1;
               end
            end
         end
         StDone: begin
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // State and beat-counter registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_cnt   <= 2'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Latch the address and write line when a request is accepted.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (r_state == StIdle) begin
         if (i_line_write) begin
            r_addr  <= {i_line_address[31:5], 5'b0};
            r_wdata <= i_line_wdata;
         end else if (i_line_read) begin
            r_addr <= {i_line_address[31:5], w_k0, 3'b0};
         end
      end
   end

   // Store each read beat into its own slice of the line.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata <= '0;
      end else if ((r_state == StRd) && i_burst_resp) begin
         for (int k = 0; k < N_BEATS; k++) begin
            if (r_cnt == 2'(k)) begin
               r_rdata[k*S_BEAT +: S_BEAT] <= i_burst_rdata;
            end
         end
      end
   end

   // Select the current write beat from the latched line.
   always_comb begin
      o_burst_wdata = '0;
      for (int k = 0; k < N_BEATS; k++) begin
         if (r_cnt == 2'(k)) begin
            o_burst_wdata = r_wdata[k*S_BEAT +: S_BEAT];
         end
      end
   end

   assign o_burst_address = r_addr;
   assign o_burst_read    = (r_state == StRd);
   assign o_burst_write   = (r_state == StWr);
   assign o_line_resp     = (r_state == StDone);
   assign o_line_rdata    = r_rdata;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Scoreboard bench for cacheline_burst_adapter. The stimulus tasks push the expected beats,
// burst start cycles and line responses into queues. A negedge monitor pops and compares them.
module tb_cacheline_burst_adapter;

   logic         clk;
   logic         rst_n;
   logic [31:0]  i_line_address;
   logic         i_line_read;
   logic         i_line_write;
   logic [255:0] i_line_wdata;
   logic [255:0] o_line_rdata;
   logic         o_line_resp;
   logic [31:0]  o_burst_address;
   logic         o_burst_read;
   logic         o_burst_write;
   logic [63:0]  o_burst_wdata;
   logic [63:0]  i_burst_rdata;
   logic         i_burst_resp;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      bit           wr;
      logic [255:0] line;
      int           lat;
      int           req_cyc;
   } resp_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [63:0] wdata;
   } beat_t;

   resp_t resp_q[$];
   beat_t beat_q[$];
   int    start_q[$];

   cacheline_burst_adapter dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_line_address  (i_line_address),
      .i_line_read     (i_line_read),
      .i_line_write    (i_line_write),
      .i_line_wdata    (i_line_wdata),
      .o_line_rdata    (o_line_rdata),
      .o_line_resp     (o_line_resp),
      .o_burst_address (o_burst_address),
      .o_burst_read    (o_burst_read),
      .o_burst_write   (o_burst_write),
      .o_burst_wdata   (o_burst_wdata),
      .i_burst_rdata   (i_burst_rdata),
      .i_burst_resp    (i_burst_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare DUT activity with the queued expectations.
   bit           prev_busy = 1'b0;
   bit           prev_resp = 1'b0;
   bit           prev_rd_beat = 1'b0;
   logic [255:0] prev_rdata = '0;

   always @(negedge clk) begin
      resp_t r;
      beat_t b;
      int    s;
      if (!rst_n) begin
         prev_busy    = 1'b0;
         prev_resp    = 1'b0;
         prev_rd_beat = 1'b0;
         prev_rdata   = o_line_rdata;
      end else begin
         if (o_burst_read || o_burst_write) begin
            if (!prev_busy) begin
               if (start_q.size() == 0) begin
                  check("unexpected_burst_start", 1'b1, 1'b0);
               end else begin
                  s = start_q.pop_front();
                  check("burst_start_cycle", cyc, s);
               end
            end
            if (beat_q.size() == 0) begin
               check("unexpected_beat", i_burst_resp, 1'b0);
            end else begin
               b = beat_q[0];
               check("burst_write_dir", o_burst_write, b.wr);
               check("burst_read_dir", o_burst_read, !b.wr);
               check("burst_address", o_burst_address, b.addr);
               if (b.wr) check("burst_wdata", o_burst_wdata, b.wdata);
               if (i_burst_resp) void'(beat_q.pop_front());
            end
         end
         if (o_line_rdata !== prev_rdata) check("rdata_changed_without_beat", prev_rd_beat, 1'b1);
         if (o_line_resp) begin
            check("resp_burst_idle", {o_burst_read, o_burst_write}, 2'b00);
            check("line_resp_width", prev_resp, 1'b0);
            if (resp_q.size() == 0) begin
               check("unexpected_line_resp", 1'b1, 1'b0);
            end else begin
               r = resp_q.pop_front();
               check("resp_latency", cyc - r.req_cyc, r.lat);
               if (!r.wr) check("line_rdata", o_line_rdata, r.line);
            end
         end
         prev_busy    = o_burst_read || o_burst_write;
         prev_resp    = o_line_resp;
         prev_rd_beat = o_burst_read && i_burst_resp;
         prev_rdata   = o_line_rdata;
      end
   end

   // One line transfer. Call this #1 after an edge while the DUT is in IDLE.
   // gap1 idle cycles are inserted before the second beat. abort_after < 4 stops after that many
   // beats, and then no response is expected.
   task automatic xfer(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [255:0] line, input logic [31:0] exp_addr, input int k0,
                       input int gap1, input int lat, input int abort_after);
      resp_t r;
      beat_t b;
      i_line_read    = rd;
      i_line_write   = wr;
      i_line_address = addr;
      i_line_wdata   = wr ? line : '0;
      start_q.push_back(cyc + 1);
      if (abort_after == 4) begin
         r.wr = wr; r.line = line; r.lat = lat; r.req_cyc = cyc;
         resp_q.push_back(r);
      end
      for (int j = 0; j < abort_after; j++) begin
         int k;
         k = (k0 + j) % 4;
         b.wr = wr; b.addr = exp_addr; b.wdata = line[k*64 +: 64];
         beat_q.push_back(b);
      end
      @(posedge clk); #1;
      for (int j = 0; j < abort_after; j++) begin
         int k;
         k = (k0 + j) % 4;
         if (j == 1) begin
            repeat (gap1) begin
               i_burst_resp = 1'b0;
               @(posedge clk); #1;
            end
         end
         i_burst_resp  = 1'b1;
         i_burst_rdata = line[k*64 +: 64];
         @(posedge clk); #1;
      end
      i_burst_resp = 1'b0;
      if (abort_after == 4) begin
         @(posedge clk); #1;
      end
      i_line_read  = 1'b0;
      i_line_write = 1'b0;
   endtask

   // Assert reset asynchronously, check that the outputs clear at once, then release it.
   task automatic reset_pulse();
      rst_n = 1'b0;
      #1;
      check("rst_line_resp", o_line_resp, 1'b0);
      check("rst_burst_read", o_burst_read, 1'b0);
      check("rst_burst_write", o_burst_write, 1'b0);
      check("rst_burst_address", o_burst_address, 32'h0);
      check("rst_burst_wdata", o_burst_wdata, 64'h0);
      check("rst_line_rdata", o_line_rdata, 256'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      errors++;
      checks++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   logic [255:0] l_rd1, l_wr, l_both, l_rd2, l_cwf, l_b2b;
   logic [31:0]  cwf_addr;
   int           cwf_k0;

   initial begin
      l_rd1  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      l_wr   = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
      l_both = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
      l_rd2  = {64'hCAFE_0003, 64'hCAFE_0002, 64'hCAFE_0001, 64'hCAFE_0000};
      l_cwf  = {64'hA3A3_A3A3, 64'hA2A2_A2A2, 64'hA1A1_A1A1, 64'hA0A0_A0A0};
      l_b2b  = {64'h5555_0003, 64'h5555_0002, 64'h5555_0001, 64'h5555_0000};
`ifdef BURST_CRITICAL_WORD_FIRST_EN
      cwf_addr = 32'h0000_1070;
      cwf_k0   = 2;
`else
      cwf_addr = 32'h0000_1060;
      cwf_k0   = 0;
`endif
      i_line_address = '0;
      i_line_read    = 1'b0;
      i_line_write   = 1'b0;
      i_line_wdata   = '0;
      i_burst_rdata  = '0;
      i_burst_resp   = 1'b0;
      @(posedge clk); #1;
      reset_pulse();

      // Aligned read, no idle cycles: line_resp five cycles after the request edge.
      xfer(1'b1, 1'b0, 32'h0000_1064, l_rd1, 32'h0000_1060, 0, 0, 5, 4);
      // Write with one idle cycle before the second beat (D1 is held while idle).
      xfer(1'b0, 1'b1, 32'h0000_2000, l_wr, 32'h0000_2000, 0, 1, 6, 4);
      // Read and write together: the write wins.
      xfer(1'b1, 1'b1, 32'h0000_301F, l_both, 32'h0000_3000, 0, 0, 5, 4);
      // Read abandoned by reset after two beats, then a normal read.
      xfer(1'b1, 1'b0, 32'h0000_3040, l_rd2, 32'h0000_3040, 0, 0, 5, 2);
      reset_pulse();
      xfer(1'b1, 1'b0, 32'h0000_3040, l_rd2, 32'h0000_3040, 0, 2, 7, 4);
      // Read of 0x1070: starts at beat 2 when critical-word-first is enabled.
      xfer(1'b1, 1'b0, 32'h0000_1070, l_cwf, cwf_addr, cwf_k0, 0, 5, 4);
      // Back-to-back reads: the second burst starts two cycles after the first line_resp.
      xfer(1'b1, 1'b0, 32'h0000_4000, l_rd1, 32'h0000_4000, 0, 0, 5, 4);
      xfer(1'b1, 1'b0, 32'h0000_5020, l_b2b, 32'h0000_5020, 0, 0, 5, 4);

      repeat (3) @(posedge clk);
      #1;
      check("resp_queue_drained", resp_q.size(), 0);
      check("beat_queue_drained", beat_q.size(), 0);
      check("start_queue_drained", start_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cacheline_burst_adapter.md
# cacheline_burst_adapter

Responder on the cache's 256-bit physical-memory line interface and initiator on a 64-bit burst memory port. Accepts one line read or line write from the L1 cache, moves it as a 4-beat burst of 64-bit words, then returns a single-cycle line response. Sits between each L1 cache's `pmem_*` port (or the arbiter in front of them) and main memory.

## Interface
- `S_LINE`, 256, line width in bits.
- `S_BEAT`, 64, burst beat width in bits; `S_LINE/S_BEAT` = 4 beats.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `line_address` in 32: line request address; bits [4:0] ignored for alignment.
- `line_read` in 1: line read request, held until `line_resp`.
- `line_write` in 1: line write request, held until `line_resp`.
- `line_wdata` in 256: write line, valid while `line_write` is high.
- `line_rdata` out 256: assembled read line, valid when `line_resp` is high.
- `line_resp` out 1: one-cycle completion pulse.
- `burst_address` out 32: line-aligned burst address, `{line_address[31:5], 5'b0}`.
- `burst_read` out 1: burst read request.
- `burst_write` out 1: burst write request.
- `burst_wdata` out 64: current write beat.
- `burst_rdata` in 64: read beat, valid when `burst_resp` is high.
- `burst_resp` in 1: per-beat acknowledge; memory may insert idle cycles between beats.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE:
  - `line_write` high: latch the address and `line_wdata`, clear the beat counter, go to WR.
  - `line_read` high (and `line_write` low): latch the address, clear the counter, go to RD.
  - Write takes priority if both are high.
- RD:
  - `burst_read`=1 with a stable address.
  - On each `burst_resp` cycle, store `burst_rdata` into line slice [64k+63:64k], where k is the beat index; the counter then increments.
  - The fourth `burst_resp` moves the FSM to DONE.
- WR:
  - `burst_write`=1; `burst_wdata` = latched line slice k.
  - Each `burst_resp` advances k; the fourth moves the FSM to DONE.
- DONE:
  - `line_resp`=1 for exactly one cycle; `burst_read`/`burst_write` low.
  - `line_rdata` holds the assembled line; its content after a write is don't-care.
  - Return to IDLE. The requester drops its request after sampling `line_resp`; requests are not sampled in DONE.
- Beat counter: 2-bit; wraps 3→0 only under the configured feature, and is never observed wrapping in default mode.
- `line_rdata` stays registered and unchanged until the next read burst writes it.
- Reset (`rst`=0, any time, including mid-burst):
  - State goes to IDLE, counter to 0.
  - `line_resp`, `burst_read`, `burst_write` go to 0; `burst_address`, `burst_wdata`, `line_rdata` go to 0.
  - A burst in progress is abandoned with no response; memory must also be reset.
- `burst_resp` while in IDLE or DONE is ignored.

## Timing
- Cycle 0: request is high at the edge; the FSM leaves IDLE.
- Cycle 1: `burst_read`/`burst_write` and `burst_address` are valid, registered outputs.
- With `burst_resp` high on cycles 1–4, DONE is cycle 5 and `line_resp` is high in cycle 5. Minimum latency is 5 cycles from the request edge.
- Each idle cycle from memory adds one cycle.
- `burst_wdata` changes only on the edge following a `burst_resp` beat.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after DONE, so the gap is 1 cycle.

## Configuration
- `BURST_CRITICAL_WORD_FIRST_EN`:
  - Defined: read bursts start at beat k0 = `line_address[4:3]`, present `burst_address = {line_address[31:5], k0, 3'b0}`, and wrap k0, k0+1, …, mod 4. Each beat is stored into its own slice.
  - Write bursts always start at beat 0.
  - Undefined: all bursts start at beat 0 and `burst_address[4:0]` = 0.

## Test plan
- Read, line address 0x0000_1064, `burst_resp` on 4 consecutive cycles with beats 0x11…, 0x22…, 0x33…, 0x44…:
  - `burst_address` = 0x0000_1060.
  - `line_rdata` = {0x44…, 0x33…, 0x22…, 0x11…}.
  - `line_resp` at cycle 5, one cycle wide.
- Write of line {D3, D2, D1, D0} with one idle cycle between beats 1 and 2:
  - `burst_wdata` sequence D0, D1, D1 (held through the idle cycle), D2, D3.
  - `line_resp` at cycle 6.
- `line_read` and `line_write` high together in IDLE → WR taken and `burst_write` = 1.
- Assert `rst` low after beat 2 of a read → all outputs 0 immediately, no `line_resp`; a following read completes normally.
- With `BURST_CRITICAL_WORD_FIRST_EN`, read 0x0000_1070:
  - `burst_address` = 0x0000_1070.
  - Beats are stored into slices 2, 3, 0, 1; the assembled line is correct.
- Two back-to-back reads → second `burst_read` rises 2 cycles after the first `line_resp`; `line_rdata` updates only during the second burst.
